// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down-counting timer with a prescaled tick,
// one-shot or auto-reload operation, pause and stop.
// Optional macro DOWN_COUNTER_TIMER_IRQ_EN adds a sticky irq output with an
// irq_clear strobe.
module down_counter_timer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             auto_reload,
`ifdef DOWN_COUNTER_TIMER_IRQ_EN
  input  logic             irq_clear,
  output logic             irq,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc_pulse
);

  localparam int unsigned     PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PS_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] start_val;
  logic             active;
  logic             tick;

  // A same-cycle load feeds start directly, so load+start begins from load_value.
  assign start_val = load ? load_value : reload_q;
  // Leaving PAUSE counts as an active cycle, so a pause of N cycles
  // delays the countdown by exactly N cycles.
  assign active    = ((state_q == RUN) || (state_q == PAUSE)) && !pause;
  assign tick      = active && (presc_q == PS_LAST);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    presc_d  = presc_q;
    tc_d     = 1'b0;
    if (stop) begin
      state_d = IDLE;
      count_d = '0;
      presc_d = '0;
    end else begin
      if (load) begin
        reload_d = load_value;
        if (state_q == IDLE) begin
          count_d = load_value;
        end
      end
      unique case (state_q)
        IDLE, DONE: begin
          if (start && (start_val != '0)) begin
            count_d = start_val;
            presc_d = '0;
            state_d = RUN;
          end
        end
        RUN, PAUSE: begin
          if (pause) begin
            state_d = PAUSE;
          end else begin
            state_d = RUN;
            if (tick) begin
              presc_d = '0;
              if (count_q > ONE) begin
                count_d = count_q - ONE;
              end else if (count_q == ONE) begin
                tc_d = 1'b1;
                if (auto_reload && (reload_q != '0)) begin
                  count_d = reload_q;
                end else begin
                  count_d = '0;
                  state_d = DONE;
                end
              end
            end else begin
              presc_d = presc_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      presc_q  <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      presc_q  <= presc_d;
      tc_q     <= tc_d;
    end
  end

`ifdef DOWN_COUNTER_TIMER_IRQ_EN
  // Sticky interrupt: a terminal count outranks a coincident clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else if (tc_q) begin
      irq <= 1'b1;
    end else if (irq_clear) begin
      irq <= 1'b0;
    end
  end
`endif

  assign count    = count_q;
  assign tc_pulse = tc_q;
  assign busy     = (state_q == RUN) || (state_q == PAUSE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: PRESCALE=1 and PRESCALE=4 instances share inputs.
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load, start, pause, stop, auto_reload;
  logic [7:0] load_value;
  logic [7:0] count1, count4;
  logic       busy1, busy4, tc1, tc4;
`ifdef DOWN_COUNTER_TIMER_IRQ_EN
  logic       irq1, irq4;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  down_counter_timer #(.WIDTH(8), .PRESCALE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .stop(stop), .auto_reload(auto_reload),
`ifdef DOWN_COUNTER_TIMER_IRQ_EN
    .irq_clear(1'b0), .irq(irq1),
`endif
    .count(count1), .busy(busy1), .tc_pulse(tc1)
  );

  down_counter_timer #(.WIDTH(8), .PRESCALE(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .stop(stop), .auto_reload(auto_reload),
`ifdef DOWN_COUNTER_TIMER_IRQ_EN
    .irq_clear(1'b0), .irq(irq4),
`endif
    .count(count4), .busy(busy4), .tc_pulse(tc4)
  );

  typedef struct {
    bit         sel;
    logic [7:0] cnt;
    logic       busy;
    logic       tc;
    string      name;
  } exp_t;

  typedef struct {
    logic       ld;
    logic [7:0] lv;
    logic       st;
    logic       ps;
    logic       sp;
    logic       ar;
    logic [7:0] ec;
    logic       eb;
    logic       et;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[9];

  task automatic push_exp(input bit sel, input logic [7:0] c, input logic b,
                          input logic t, input string nm);
    exp_t e;
    e.sel = sel; e.cnt = c; e.busy = b; e.tc = t; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic compare_head();
    exp_t       e;
    logic [7:0] ac;
    logic       ab, at;
    e  = sb.pop_front();
    ac = e.sel ? count4 : count1;
    ab = e.sel ? busy4  : busy1;
    at = e.sel ? tc4    : tc1;
    checks++;
    if (ac !== e.cnt || ab !== e.busy || at !== e.tc) begin
      failures++;
      $display("FAIL %s: got count=%0d busy=%b tc=%b, want count=%0d busy=%b tc=%b",
               e.name, ac, ab, at, e.cnt, e.busy, e.tc);
    end
  endtask

  // Expectation for the outputs after the next rising edge; strobes last one cycle.
  task automatic expect_next(input bit sel, input logic [7:0] c, input logic b,
                             input logic t, input string nm);
    push_exp(sel, c, b, t, nm);
    @(posedge clk);
    #1;
    load  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    compare_head();
  endtask

  task automatic check_now(input bit sel, input logic [7:0] c, input logic b,
                           input logic t, input string nm);
    push_exp(sel, c, b, t, nm);
    compare_head();
  endtask

  task automatic do_reset();
    load = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    auto_reload = 1'b0; load_value = '0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] e_cnt;
    logic       e_tc;

    tbl[0] = '{1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0};

    do_reset();
    check_now(1'b0, 8'd0, 1'b0, 1'b0, "reset_p1");
    check_now(1'b1, 8'd0, 1'b0, 1'b0, "reset_p4");

    // One-shot, PRESCALE=1, then restart from DONE.
    for (int unsigned i = 0; i < 9; i++) begin
      load = tbl[i].ld; load_value = tbl[i].lv; start = tbl[i].st;
      pause = tbl[i].ps; stop = tbl[i].sp; auto_reload = tbl[i].ar;
      expect_next(1'b0, tbl[i].ec, tbl[i].eb, tbl[i].et, $sformatf("oneshot[%0d]", i));
    end

    // Periodic, PRESCALE=4, reload 3: tc every 12 cycles.
    do_reset();
    auto_reload = 1'b1;
    load = 1'b1; load_value = 8'd3;
    expect_next(1'b1, 8'd3, 1'b0, 1'b0, "p4_load");
    start = 1'b1;
    expect_next(1'b1, 8'd3, 1'b1, 1'b0, "p4_start");
    for (int unsigned k = 1; k <= 36; k++) begin
      e_cnt = 8'(3 - ((k / 4) % 3));
      e_tc  = ((k % 12) == 0);
      expect_next(1'b1, e_cnt, 1'b1, e_tc, $sformatf("p4_run[%0d]", k));
    end
    stop = 1'b1;
    expect_next(1'b1, 8'd0, 1'b0, 1'b0, "p4_stop");

    // Pause for 7 cycles at count 6: terminal count moves out by 7 cycles.
    do_reset();
    load = 1'b1; load_value = 8'd10;
    expect_next(1'b0, 8'd10, 1'b0, 1'b0, "pz_load");
    start = 1'b1;
    expect_next(1'b0, 8'd10, 1'b1, 1'b0, "pz_start");
    for (int unsigned k = 1; k <= 4; k++)
      expect_next(1'b0, 8'(10 - k), 1'b1, 1'b0, $sformatf("pz_pre[%0d]", k));
    pause = 1'b1;
    for (int unsigned k = 0; k < 7; k++)
      expect_next(1'b0, 8'd6, 1'b1, 1'b0, $sformatf("pz_hold[%0d]", k));
    pause = 1'b0;
    for (int unsigned k = 1; k <= 5; k++)
      expect_next(1'b0, 8'(6 - k), 1'b1, 1'b0, $sformatf("pz_post[%0d]", k));
    expect_next(1'b0, 8'd0, 1'b0, 1'b1, "pz_tc");

    // Stop mid-run at count 3, then restart from the kept reload value.
    do_reset();
    load = 1'b1; load_value = 8'd8;
    expect_next(1'b0, 8'd8, 1'b0, 1'b0, "st_load");
    start = 1'b1;
    expect_next(1'b0, 8'd8, 1'b1, 1'b0, "st_start");
    for (int unsigned k = 1; k <= 5; k++)
      expect_next(1'b0, 8'(8 - k), 1'b1, 1'b0, $sformatf("st_run[%0d]", k));
    stop = 1'b1;
    expect_next(1'b0, 8'd0, 1'b0, 1'b0, "st_stop");
    expect_next(1'b0, 8'd0, 1'b0, 1'b0, "st_idle");
    start = 1'b1;
    expect_next(1'b0, 8'd8, 1'b1, 1'b0, "st_restart");
    expect_next(1'b0, 8'd7, 1'b1, 1'b0, "st_restart_dec");

    // Asynchronous reset between edges, then start with a zero reload.
    do_reset();
    load = 1'b1; load_value = 8'd6;
    expect_next(1'b0, 8'd6, 1'b0, 1'b0, "ar_load");
    start = 1'b1;
    expect_next(1'b0, 8'd6, 1'b1, 1'b0, "ar_start");
    expect_next(1'b0, 8'd5, 1'b1, 1'b0, "ar_run5");
    expect_next(1'b0, 8'd4, 1'b1, 1'b0, "ar_run4");
    #3;
    reset_n = 1'b0;
    #1;
    check_now(1'b0, 8'd0, 1'b0, 1'b0, "async_reset");
    #2;
    reset_n = 1'b1;
    start = 1'b1;
    expect_next(1'b0, 8'd0, 1'b0, 1'b0, "start_zero_reload");

    // Auto-reload picks up a mid-run load at the next period; load+start in IDLE.
    do_reset();
    auto_reload = 1'b1;
    load = 1'b1; load_value = 8'd2;
    expect_next(1'b0, 8'd2, 1'b0, 1'b0, "rl_load");
    start = 1'b1;
    expect_next(1'b0, 8'd2, 1'b1, 1'b0, "rl_start");
    expect_next(1'b0, 8'd1, 1'b1, 1'b0, "rl_run1");
    expect_next(1'b0, 8'd2, 1'b1, 1'b1, "rl_tc1");
    load = 1'b1; load_value = 8'd5;
    expect_next(1'b0, 8'd1, 1'b1, 1'b0, "rl_load_in_run");
    expect_next(1'b0, 8'd5, 1'b1, 1'b1, "rl_tc2_new_value");
    expect_next(1'b0, 8'd4, 1'b1, 1'b0, "rl_run4");
    stop = 1'b1;
    expect_next(1'b0, 8'd0, 1'b0, 1'b0, "rl_stop");
    auto_reload = 1'b0;
    load = 1'b1; load_value = 8'd7; start = 1'b1;
    expect_next(1'b0, 8'd7, 1'b1, 1'b0, "ld_start_same");
    expect_next(1'b0, 8'd6, 1'b1, 1'b0, "ld_start_dec");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable down-counting timer; the count-down counterpart of the free-running enable-gated up counter in the same library.
- Counts a programmed reload value down to zero at a prescaled tick rate and signals terminal count with a one-cycle pulse.
- Supports one-shot and auto-reload (periodic) operation, pause and stop.
- Sits beside the up counter in control and timing logic; feeds timeouts and periodic strobes to downstream FSMs.

Parameters:
- WIDTH, 8, bit width of reload value and count.
- PRESCALE, 1, clock cycles per decrement tick; legal range >= 1; PRESCALE=1 means tick every cycle.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  reset, asynchronous and active-low.
- load  input  1  single-cycle strobe; captures load_value into the reload register.
- load_value  input  WIDTH  reload value.
- start  input  1  single-cycle strobe; begins countdown from the reload register.
- pause  input  1  level; freezes counting while high in RUN.
- stop  input  1  single-cycle strobe; aborts to IDLE.
- auto_reload  input  1  level; 1 = periodic mode, 0 = one-shot.
- count  output  WIDTH  current count value (registered).
- busy  output  1  high in RUN or PAUSE.
- tc_pulse  output  1  one-cycle terminal-count strobe (registered).

Behaviour:
- Reset (reset_n low, async): state=IDLE, count=0, reload_reg=0, prescaler=0, busy=0, tc_pulse=0.
- States: IDLE, RUN, PAUSE, DONE. busy = (state==RUN or state==PAUSE).
- Per-cycle priority: stop > load > start > pause.
- stop: any state -> IDLE at the next edge; count<=0; prescaler<=0; tc_pulse<=0.
- load:
  - Legal in any state; reload_reg<=load_value.
  - In IDLE, also count<=load_value.
  - Never changes state. In RUN/PAUSE, the new value takes effect at the next reload only.
- start:
  - In IDLE or DONE with reload_reg!=0: count<=reload_reg, prescaler<=0, state->RUN.
  - With reload_reg==0: ignored, state unchanged.
  - In RUN/PAUSE: ignored (no restart).
- Same-cycle load+start in IDLE: start uses the newly loaded value (load_value).
- tick: asserted in RUN when prescaler==PRESCALE-1. prescaler<=0 on tick, else it increments; it increments only in RUN.
- RUN, tick, count>1: count<=count-1.
- RUN, tick, count==1:
  - tc_pulse<=1 at the same edge.
  - If auto_reload=1: count<=reload_reg and stay in RUN. If reload_reg is 0 at that moment: count<=0 and go to DONE.
  - If auto_reload=0: count<=0, state->DONE.
- tc_pulse is high exactly one cycle per terminal count; otherwise 0.
- Periodic period = reload_reg*PRESCALE cycles between tc_pulse assertions.
- First tc_pulse after start is high in cycle N*PRESCALE after the start edge (N = reload value).
- RUN with pause=1: state->PAUSE; count and prescaler frozen; no tick that cycle.
- PAUSE with pause=0: state->RUN; resumes with the preserved prescaler phase.
- DONE: count holds 0, busy=0; leave via start or stop.
- No wrap-around: count never decrements below 0.
- Arithmetic is unsigned WIDTH bits; maximum reload is 2^WIDTH-1.

Optional Feature:
- Macro: DOWN_COUNTER_TIMER_IRQ_EN.
- Defined: adds input irq_clear (1 bit) and output irq (1 bit, reset 0).
  - irq sets on any tc_pulse and stays high until an irq_clear strobe.
  - Same-cycle tc_pulse and irq_clear: set wins, irq stays 1.
  - stop does not clear irq.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- PRESCALE=1, load 5, start, auto_reload=0 -> count reads 4,3,2,1,0 on successive cycles; tc_pulse high only in the cycle count=0; state DONE; busy=0.
- PRESCALE=4, load 3, start, auto_reload=1 -> tc_pulse every 12 cycles for 3 periods; count cycles 2,1,3,... with each value held 4 cycles.
- Load 10, start; at count=6 assert pause for 7 cycles -> count holds 6, busy=1; after release the countdown resumes and the first tc_pulse is delayed exactly 7 cycles.
- Load 8, start; stop when count=3 -> next cycle count=0, busy=0, state IDLE, no tc_pulse; a new start restarts from 8.
- Reset_n low mid-RUN (count=4), asynchronously between edges -> count=0, busy=0, tc_pulse=0 immediately; with reload_reg=0 after reset, start is ignored.
- auto_reload=1, load 2, start; load 5 during RUN -> next period counts from 5; same-cycle load 7 + start from IDLE -> counts from 7.
